board_overlay: RTL and testbench

Upstream companion to the PPU pixel path. Holds the live game state of both 10x10 Battleship grids and turns the VGA driver's `next_x`/`next_y` into a per-pixel overlay colour. The PPU muxes this colour over the board ROM pixel. Output is registered with 1-cycle latency so it lines up with the board ROM `q` and the PPU's `curr_x`/`curr_y`.

---
 rtl/board_overlay.sv | 134 +++++++++++++
 tb/tb_board_overlay.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_overlay.sv
// Live state of both 10x10 Battleship grids plus the per-pixel overlay lookup.
// The overlay colour is registered so it lines up with the board ROM output.
module board_overlay #(
  parameter int BOARD_OFFSET_X  = 234,
  parameter int BOARD1_OFFSET_Y = 67,
  parameter int BOARD_SIZE      = 173,
  parameter int BOARD2_OFFSET_Y = BOARD1_OFFSET_Y + BOARD_SIZE,
  parameter int BORDER          = 2,
  parameter int CELL            = 17,
  parameter int MARK_LO         = 4,
  parameter int MARK_HI         = 12
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic       wr_en,
  input  logic       wr_board,
  input  logic [3:0] wr_row,
  input  logic [3:0] wr_col,
  input  logic [1:0] wr_state,
  output logic       wr_ready,
  output logic       wr_err,
  input  logic       clr,
  output logic       clr_busy,
  output logic       ov_valid,
  output logic [7:0] ov_rgb
);

  localparam int NCELL = 200;
  localparam int GRID  = 10 * CELL;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt;
  logic [1:0] r_cells [NCELL];
  logic       r_wr_err;
  logic       r_ov_valid;
  logic [7:0] r_ov_rgb;

  int         w_cx, w_cy, w_col, w_row, w_px, w_py, w_idx, w_wr_idx;
  logic       w_board, w_in, w_mark, w_hit, w_wr_oob, w_wr_go;
  logic [1:0] w_st;
  logic [7:0] w_rgb;

  // Exact quotient for 0..169 via a compare chain; saturates at 9.
  function automatic int div_cell(input int v);
    int q;
    q = 0;
    for (int k = 1; k < 10; k++)
      if (v >= k * CELL) q = k;
    return q;
  endfunction

  always_comb begin
    w_board = (int'(next_y) >= BOARD2_OFFSET_Y);
    w_cx    = int'(next_x) - BOARD_OFFSET_X - BORDER;
    w_cy    = int'(next_y) - (w_board ? BOARD2_OFFSET_Y : BOARD1_OFFSET_Y) - BORDER;
    w_in    = (w_cx >= 0) && (w_cx < GRID) && (w_cy >= 0) && (w_cy < GRID) &&
              (int'(next_y) < BOARD2_OFFSET_Y + BOARD_SIZE);
    w_col   = div_cell(w_cx);
    w_row   = div_cell(w_cy);
    w_px    = w_cx - w_col * CELL;
    w_py    = w_cy - w_row * CELL;
    w_mark  = w_in && (w_px >= MARK_LO) && (w_px <= MARK_HI) &&
              (w_py >= MARK_LO) && (w_py <= MARK_HI);
    w_idx   = (w_board ? 100 : 0) + w_row * 10 + w_col;
    w_st    = w_mark ? r_cells[w_idx[7:0]] : 2'd0;
    w_hit   = 1'b0;
    w_rgb   = 8'h00;
    case (w_st)
      2'd1: begin w_hit = !w_board; w_rgb = w_board ? 8'h00 : 8'h92; end
      2'd2: begin w_hit = 1'b1;     w_rgb = 8'hFF; end
      2'd3: begin w_hit = 1'b1;     w_rgb = 8'hE0; end
      default: ;
    endcase
  end

  always_comb begin
    w_wr_oob = (wr_row > 4'd9) || (wr_col > 4'd9);
    w_wr_go  = wr_en && wr_ready && !w_wr_oob;
    w_wr_idx = (wr_board ? 100 : 0) + int'(wr_row) * 10 + int'(wr_col);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clr) w_state_nxt = S_SWEEP;
      S_SWEEP: if (r_cnt == 8'd199) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == S_SWEEP) ? r_cnt + 8'd1 : 8'd0;
    end
  end

  // Writes are blocked while sweeping, so the two never collide.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCELL; i++) r_cells[i] <= 2'd0;
    end else if (r_state == S_SWEEP) begin
      r_cells[r_cnt] <= 2'd0;
    end else if (w_wr_go) begin
      r_cells[w_wr_idx[7:0]] <= wr_state;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err   <= 1'b0;
      r_ov_valid <= 1'b0;
      r_ov_rgb   <= 8'h00;
    end else begin
      r_wr_err   <= wr_en && wr_ready && w_wr_oob;
      r_ov_valid <= w_hit;
      r_ov_rgb   <= w_rgb;
    end
  end

  assign clr_busy = (r_state == S_SWEEP);
  assign wr_ready = (r_state == S_IDLE);
  assign wr_err   = r_wr_err;
  assign ov_valid = r_ov_valid;
  assign ov_rgb   = r_ov_rgb;

endmodule

// File: tb/tb_board_overlay.sv
// Randomised bench for board_overlay against a cycle-stamped grid model.
module tb_board_overlay;

  logic       vga_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] next_x  = '0;
  logic [9:0] next_y  = '0;
  logic       wr_en   = 1'b0;
  logic       wr_board = 1'b0;
  logic [3:0] wr_row  = '0;
  logic [3:0] wr_col  = '0;
  logic [1:0] wr_state = '0;
  logic       wr_ready, wr_err, clr, clr_busy, ov_valid;
  logic [7:0] ov_rgb;

  initial clr = 1'b0;

  board_overlay dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .next_x(next_x), .next_y(next_y),
    .wr_en(wr_en), .wr_board(wr_board), .wr_row(wr_row), .wr_col(wr_col),
    .wr_state(wr_state), .wr_ready(wr_ready), .wr_err(wr_err), .clr(clr),
    .clr_busy(clr_busy), .ov_valid(ov_valid), .ov_rgb(ov_rgb)
  );

  always #20 vga_clk = ~vga_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int model [200];
  int edge_n = 0;
  int clr_start = -1000;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic void reset_model();
    for (int i = 0; i < 200; i++) model[i] = 0;
    clr_start = -1000;
  endfunction

  function automatic bit in_sweep(input int e);
    return (e >= clr_start) && (e <= clr_start + 199);
  endfunction

  // Overlay colour for a pixel from the grid rules; -1 means no overlay.
  function automatic int pix_rgb(input int x, input int y);
    int b, ly, cx, cy, s;
    if (x < 236 || x >= 236 + 170) return -1;
    if (y >= 67 && y < 240)       begin b = 0; ly = y - 67;  end
    else if (y >= 240 && y < 413) begin b = 1; ly = y - 240; end
    else return -1;
    if (ly < 2 || ly >= 172) return -1;
    cx = x - 236;
    cy = ly - 2;
    if (cx % 17 < 4 || cx % 17 > 12 || cy % 17 < 4 || cy % 17 > 12) return -1;
    s = model[b * 100 + (cy / 17) * 10 + cx / 17];
    case (s)
      1: return (b == 0) ? 'h92 : -1;
      2: return 'hFF;
      3: return 'hE0;
      default: return -1;
    endcase
  endfunction

  // One clock: predict from the pre-edge model and inputs, advance the model, compare.
  task automatic tick();
    int exp_rgb;
    bit busy_pre, oob, err_x;
    @(posedge vga_clk);
    exp_rgb = -1;
    err_x   = 1'b0;
    if (!rst_n) begin
      reset_model();
    end else begin
      edge_n++;
      busy_pre = in_sweep(edge_n - 1);
      exp_rgb  = pix_rgb(int'(next_x), int'(next_y));
      oob      = (wr_row > 4'd9) || (wr_col > 4'd9);
      err_x    = wr_en && !busy_pre && oob;
      if (wr_en && !busy_pre && !oob)
        model[int'(wr_board) * 100 + int'(wr_row) * 10 + int'(wr_col)] = int'(wr_state);
      if (busy_pre) model[edge_n - clr_start - 1] = 0;
      if (clr && !busy_pre) clr_start = edge_n;
    end
    #1;
    chk("ov_valid", int'(ov_valid), (exp_rgb >= 0) ? 1 : 0);
    chk("ov_rgb", int'(ov_rgb), (exp_rgb >= 0) ? exp_rgb : 0);
    chk("wr_err", int'(wr_err), int'(err_x));
    chk("clr_busy", int'(clr_busy), (rst_n && in_sweep(edge_n)) ? 1 : 0);
    chk("wr_ready", int'(wr_ready), (rst_n && in_sweep(edge_n)) ? 0 : 1);
  endtask

  task automatic look(input int x, input int y);
    next_x = 10'(x);
    next_y = 10'(y);
    tick();
  endtask

  task automatic wr(input int b, input int r, input int c, input int s);
    wr_en = 1'b1; wr_board = 1'(b); wr_row = 4'(r); wr_col = 4'(c); wr_state = 2'(s);
    tick();
    wr_en = 1'b0;
  endtask

  function automatic int mx(input int c);
    return 240 + c * 17;
  endfunction

  function automatic int my(input int b, input int r);
    return (b != 0 ? 240 : 67) + 6 + r * 17;
  endfunction

  task automatic scan_cells(output int nz);
    nz = 0;
    for (int i = 0; i < 200; i++) begin
      look(mx(i % 10), my(i / 100, (i / 10) % 10));
      if (ov_valid) nz++;
    end
  endtask

  initial begin
    int busy_cnt, nz;
    reset_model();
    repeat (3) tick();
    chk("rst_ov_valid", int'(ov_valid), 0);
    chk("rst_ov_rgb", int'(ov_rgb), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_clr_busy", int'(clr_busy), 0);
    chk("rst_wr_err", int'(wr_err), 0);
    rst_n = 1'b1;

    // Sparse full-range scan of an empty board, blanking values included.
    for (int y = 0; y < 1024; y += 11)
      for (int x = 0; x < 1024; x += 13)
        look(x, y);

    wr(0, 3, 5, 3);
    look(325, 124);
    chk("b0_r3c5_valid", int'(ov_valid), 1);
    chk("b0_r3c5_rgb", int'(ov_rgb), 'hE0);
    look(322, 124);
    chk("b0_r3c5_px1", int'(ov_valid), 0);

    wr(1, 0, 0, 1);
    look(240, 246);
    chk("enemy_ship_hidden", int'(ov_valid), 0);
    wr(1, 0, 0, 2);
    look(240, 246);
    chk("b1_miss_rgb", int'(ov_rgb), 'hFF);

    wr_en = 1'b1; wr_board = 1'b0; wr_row = 4'd10; wr_col = 4'd0; wr_state = 2'd3;
    tick();
    wr_en = 1'b0;
    chk("wr_err_pulse", int'(wr_err), 1);
    tick();
    chk("wr_err_once", int'(wr_err), 0);
    wr(1, 2, 12, 3);
    look(240, 246);
    chk("oob_no_alias", int'(ov_rgb), 'hFF);
    wr(1, 9, 9, 2);
    look(393, 399);
    chk("b1_r9c9_rgb", int'(ov_rgb), 'hFF);
    look(391, 397);

    // Clear sweep with a second clr and a write landing mid-sweep.
    for (int i = 0; i < 5; i++)
      wr(int'($urandom_range(0, 1)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
         int'($urandom_range(1, 3)));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_cnt = clr_busy ? 1 : 0;
    for (int i = 1; i < 260; i++) begin
      clr   = (i == 50);
      wr_en = (i == 100);
      wr_board = 1'b0; wr_row = 4'd9; wr_col = 4'd9; wr_state = 2'd3;
      next_x = 10'(mx(int'($urandom_range(0, 9))) + int'($urandom_range(0, 8)));
      next_y = 10'(my(int'($urandom_range(0, 1)), int'($urandom_range(0, 9))));
      tick();
      if (clr_busy) busy_cnt++;
    end
    clr = 1'b0; wr_en = 1'b0;
    chk("clr_busy_cycles", busy_cnt, 200);
    scan_cells(nz);
    chk("cleared_cells", nz, 0);

    // Write on the same edge that samples the pixel of that cell.
    next_x = 10'(mx(2)); next_y = 10'(my(0, 2));
    wr(0, 2, 2, 2);
    chk("same_cycle_old", int'(ov_valid), 0);
    tick();
    chk("same_cycle_new", int'(ov_rgb), 'hFF);

    for (int i = 0; i < 4000; i++) begin
      int b, r, c;
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_board = 1'($urandom_range(0, 1));
      wr_row   = 4'($urandom_range(0, 11));
      wr_col   = 4'($urandom_range(0, 11));
      wr_state = 2'($urandom_range(0, 3));
      clr      = ($urandom_range(0, 599) == 0);
      b = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      c = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) != 0) begin
        next_x = 10'(236 + c * 17 + int'($urandom_range(0, 16)));
        next_y = 10'((b != 0 ? 240 : 67) + 2 + r * 17 + int'($urandom_range(0, 16)));
      end else begin
        next_x = 10'($urandom_range(0, 1023));
        next_y = 10'($urandom_range(0, 1023));
      end
      tick();
    end
    wr_en = 1'b0; clr = 1'b0;
    repeat (210) tick();

    // Reset in the middle of a sweep.
    wr(1, 5, 0, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    next_x = 10'(mx(0)); next_y = 10'(my(1, 5));
    repeat (60) tick();
    chk("pre_reset_rgb", int'(ov_rgb), 'hE0);
    rst_n = 1'b0;
    #1;
    reset_model();
    chk("midrst_ov_valid", int'(ov_valid), 0);
    chk("midrst_ov_rgb", int'(ov_rgb), 0);
    chk("midrst_clr_busy", int'(clr_busy), 0);
    chk("midrst_wr_ready", int'(wr_ready), 1);
    chk("midrst_wr_err", int'(wr_err), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    scan_cells(nz);
    chk("post_reset_cells", nz, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
